rect_rasterizer: RTL and testbench

//  Parametrised successor of the full-screen rasterizer. Accepts filled-rectangle draw commands

---
 rtl/rect_rasterizer.sv | 175 +++++++++++++++++
 tb/tb_rect_rasterizer.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_rasterizer.sv
// rect_rasterizer: accepts filled-rectangle draw commands over valid/ready and
// emits one framebuffer pixel write per cycle in raster order, honouring
// backpressure from the framebuffer write port.
// Build option: define RASTER_CLIP_EN to clamp out-of-range corners to the frame
// edge instead of rejecting the command with o_error.
module rect_rasterizer #(
  parameter int VERT_RESOLUTION  = 60,
  parameter int HORIZ_RESOLUTION = 80,
  parameter int COLOR_WIDTH      = 4,
  localparam int VW = $clog2(VERT_RESOLUTION),
  localparam int HW = $clog2(HORIZ_RESOLUTION)
) (
  input  logic                   i_clk,
  input  logic                   i_srst,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [HW-1:0]          i_cmd_x0,
  input  logic [HW-1:0]          i_cmd_x1,
  input  logic [VW-1:0]          i_cmd_y0,
  input  logic [VW-1:0]          i_cmd_y1,
  input  logic [COLOR_WIDTH-1:0] i_cmd_red,
  input  logic [COLOR_WIDTH-1:0] i_cmd_green,
  input  logic [COLOR_WIDTH-1:0] i_cmd_blue,
  output logic [VW-1:0]          o_vert_write_addr,
  output logic [HW-1:0]          o_horiz_write_addr,
  output logic [COLOR_WIDTH-1:0] o_red,
  output logic [COLOR_WIDTH-1:0] o_green,
  output logic [COLOR_WIDTH-1:0] o_blue,
  output logic                   o_write_en,
  input  logic                   i_write_ready,
  output logic                   o_done,
  output logic                   o_error
);

  localparam logic [HW-1:0] HMAX = HW'(HORIZ_RESOLUTION - 1);
  localparam logic [VW-1:0] VMAX = VW'(VERT_RESOLUTION - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRAW,
    DONE
  } state_e;

  state_e                 state_q;
  logic [HW-1:0]          cmdX0_q, cmdX1_q;
  logic [VW-1:0]          cmdY0_q, cmdY1_q;
  logic [COLOR_WIDTH-1:0] cmdRed_q, cmdGreen_q, cmdBlue_q;
  logic [HW-1:0]          xMin_q, xMax_q;
  logic [VW-1:0]          yMax_q;

  logic [HW-1:0]          clipX0, clipX1;
  logic [VW-1:0]          clipY0, clipY1;
  logic [HW-1:0]          xMin_d, xMax_d;
  logic [VW-1:0]          yMin_d, yMax_d;
  logic                   rangeErr;

  // Sort the latched corners into a bounding box, after clamping or range-checking them
  always_comb begin
    clipX0 = cmdX0_q;
    clipX1 = cmdX1_q;
    clipY0 = cmdY0_q;
    clipY1 = cmdY1_q;
`ifdef RASTER_CLIP_EN
    if (cmdX0_q > HMAX) clipX0 = HMAX;
    if (cmdX1_q > HMAX) clipX1 = HMAX;
    if (cmdY0_q > VMAX) clipY0 = VMAX;
    if (cmdY1_q > VMAX) clipY1 = VMAX;
    rangeErr = 1'b0;
`else
    rangeErr = (cmdX0_q > HMAX) || (cmdX1_q > HMAX) ||
               (cmdY0_q > VMAX) || (cmdY1_q > VMAX);
`endif
    xMin_d = (clipX0 < clipX1) ? clipX0 : clipX1;
    xMax_d = (clipX0 < clipX1) ? clipX1 : clipX0;
    yMin_d = (clipY0 < clipY1) ? clipY0 : clipY1;
    yMax_d = (clipY0 < clipY1) ? clipY1 : clipY0;
  end

  // Command FSM: latch a command, set up its box, walk it pixel by pixel, pulse done
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q            <= IDLE;
      o_cmd_ready        <= 1'b1;
      o_write_en         <= 1'b0;
      o_done             <= 1'b0;
      o_error            <= 1'b0;
      o_vert_write_addr  <= '0;
      o_horiz_write_addr <= '0;
      o_red              <= '0;
      o_green            <= '0;
      o_blue             <= '0;
      cmdX0_q            <= '0;
      cmdX1_q            <= '0;
      cmdY0_q            <= '0;
      cmdY1_q            <= '0;
      cmdRed_q           <= '0;
      cmdGreen_q         <= '0;
      cmdBlue_q          <= '0;
      xMin_q             <= '0;
      xMax_q             <= '0;
      yMax_q             <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          o_done  <= 1'b0;
          o_error <= 1'b0;
          if (i_cmd_valid && o_cmd_ready) begin
            cmdX0_q     <= i_cmd_x0;
            cmdX1_q     <= i_cmd_x1;
            cmdY0_q     <= i_cmd_y0;
            cmdY1_q     <= i_cmd_y1;
            cmdRed_q    <= i_cmd_red;
            cmdGreen_q  <= i_cmd_green;
            cmdBlue_q   <= i_cmd_blue;
            o_cmd_ready <= 1'b0;
            state_q     <= SETUP;
          end
        end

        SETUP: begin
          xMin_q  <= xMin_d;
          xMax_q  <= xMax_d;
          yMax_q  <= yMax_d;
          o_red   <= cmdRed_q;
          o_green <= cmdGreen_q;
          o_blue  <= cmdBlue_q;
          if (rangeErr) begin
            o_done  <= 1'b1;
            o_error <= 1'b1;
            state_q <= DONE;
          end else begin
            o_vert_write_addr  <= yMin_d;
            o_horiz_write_addr <= xMin_d;
            o_write_en         <= 1'b1;
            state_q            <= DRAW;
          end
        end

        DRAW: begin
          if (i_write_ready) begin
            if (o_horiz_write_addr == xMax_q) begin
              if (o_vert_write_addr == yMax_q) begin
                o_write_en <= 1'b0;
                o_done     <= 1'b1;
                state_q    <= DONE;
              end else begin
                o_horiz_write_addr <= xMin_q;
                o_vert_write_addr  <= o_vert_write_addr + VW'(1);
              end
            end else begin
              o_horiz_write_addr <= o_horiz_write_addr + HW'(1);
            end
          end
        end

        DONE: begin
          o_done      <= 1'b0;
          o_error     <= 1'b0;
          o_cmd_ready <= 1'b1;
          state_q     <= IDLE;
        end

        default: begin
          state_q     <= IDLE;
          o_cmd_ready <= 1'b1;
          o_write_en  <= 1'b0;
          o_done      <= 1'b0;
          o_error     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_rasterizer.sv
// Testbench for rect_rasterizer: directed scenarios plus randomized commands,
// checked every cycle against a pixel-list model of each rectangle.
module tb_rect_rasterizer;

  localparam int VRES = 60;
  localparam int HRES = 80;
  localparam int CW   = 4;
  localparam int VW   = $clog2(VRES);
  localparam int HW   = $clog2(HRES);

  logic          i_clk = 1'b0;
  logic          i_srst = 1'b1;
  logic          i_cmd_valid = 1'b0;
  logic          o_cmd_ready;
  logic [HW-1:0] i_cmd_x0 = '0;
  logic [HW-1:0] i_cmd_x1 = '0;
  logic [VW-1:0] i_cmd_y0 = '0;
  logic [VW-1:0] i_cmd_y1 = '0;
  logic [CW-1:0] i_cmd_red = '0;
  logic [CW-1:0] i_cmd_green = '0;
  logic [CW-1:0] i_cmd_blue = '0;
  logic [VW-1:0] o_vert_write_addr;
  logic [HW-1:0] o_horiz_write_addr;
  logic [CW-1:0] o_red, o_green, o_blue;
  logic          o_write_en;
  logic          i_write_ready = 1'b1;
  logic          o_done;
  logic          o_error;

  rect_rasterizer #(
    .VERT_RESOLUTION (VRES),
    .HORIZ_RESOLUTION(HRES),
    .COLOR_WIDTH     (CW)
  ) dut (
    .i_clk             (i_clk),
    .i_srst            (i_srst),
    .i_cmd_valid       (i_cmd_valid),
    .o_cmd_ready       (o_cmd_ready),
    .i_cmd_x0          (i_cmd_x0),
    .i_cmd_x1          (i_cmd_x1),
    .i_cmd_y0          (i_cmd_y0),
    .i_cmd_y1          (i_cmd_y1),
    .i_cmd_red         (i_cmd_red),
    .i_cmd_green       (i_cmd_green),
    .i_cmd_blue        (i_cmd_blue),
    .o_vert_write_addr (o_vert_write_addr),
    .o_horiz_write_addr(o_horiz_write_addr),
    .o_red             (o_red),
    .o_green           (o_green),
    .o_blue            (o_blue),
    .o_write_en        (o_write_en),
    .i_write_ready     (i_write_ready),
    .o_done            (o_done),
    .o_error           (o_error)
  );

  // Free-running clock
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Model state: owned by the monitor process
  int cyc = 0;
  int busy = 0;
  int expErr = 0;
  int acceptCyc = 0;
  int doneDue = -1;
  int npix = 0;
  int stalls = 0;
  int expR = 0, expG = 0, expB = 0;
  int expQ[$];
  int prevSrst = 0;
  int lastAcceptCyc = 0;
  int lastDoneCyc = -1000;
  int lastErr = 0;
  int writeLog[$];

  int readyMode = 0;
  int patIdx = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  function automatic int logAt(input int i);
    if (i < writeLog.size()) return writeLog[i];
    return -1;
  endfunction

  // Reference model and per-cycle compare, sampled on the falling edge
  always @(negedge i_clk) begin
    int acc, expWe, expDone, head;
    int x0, x1, y0, y1, xmn, xmx, ymn, ymx;
    cyc++;
    acc = (i_cmd_valid && busy == 0) ? 1 : 0;
    expDone = 0;
    if (prevSrst != 0) begin
      checkOutput("rst_write_en", int'(o_write_en), 0);
      checkOutput("rst_cmd_ready", int'(o_cmd_ready), 1);
      checkOutput("rst_done", int'(o_done), 0);
      checkOutput("rst_error", int'(o_error), 0);
      checkOutput("rst_vert", int'(o_vert_write_addr), 0);
      checkOutput("rst_horiz", int'(o_horiz_write_addr), 0);
      checkOutput("rst_colour", int'({o_red, o_green, o_blue}), 0);
    end else begin
      expWe = (busy != 0 && expErr == 0 && expQ.size() > 0 && cyc >= acceptCyc + 2) ? 1 : 0;
      expDone = (busy != 0 && cyc == doneDue) ? 1 : 0;
      checkOutput("cmd_ready", int'(o_cmd_ready), (busy == 0) ? 1 : 0);
      checkOutput("write_en", int'(o_write_en), expWe);
      checkOutput("done", int'(o_done), expDone);
      checkOutput("error", int'(o_error), (expDone != 0 && expErr != 0) ? 1 : 0);
      if (o_write_en && expQ.size() > 0) begin
        head = expQ[0];
        checkOutput("vert_addr", int'(o_vert_write_addr), head / 256);
        checkOutput("horiz_addr", int'(o_horiz_write_addr), head % 256);
        checkOutput("red", int'(o_red), expR);
        checkOutput("green", int'(o_green), expG);
        checkOutput("blue", int'(o_blue), expB);
      end
      if (o_done && busy != 0) begin
        lastDoneCyc = cyc;
        lastErr = int'(o_error);
        checkOutput("done_latency", cyc - acceptCyc, (expErr != 0) ? 2 : 2 + npix + stalls);
      end
    end

    if (i_srst) begin
      expQ.delete();
      busy = 0;
      doneDue = -1;
    end else begin
      if (o_write_en && i_write_ready) begin
        writeLog.push_back(int'(o_vert_write_addr) * 256 + int'(o_horiz_write_addr));
        if (busy != 0 && expQ.size() > 0) begin
          void'(expQ.pop_front());
          if (expQ.size() == 0) doneDue = cyc + 1;
        end
      end
      if (o_write_en && !i_write_ready && busy != 0) stalls++;
      if (expDone != 0) busy = 0;
      if (acc != 0) begin
        x0 = int'(i_cmd_x0);
        x1 = int'(i_cmd_x1);
        y0 = int'(i_cmd_y0);
        y1 = int'(i_cmd_y1);
`ifdef RASTER_CLIP_EN
        if (x0 > HRES - 1) x0 = HRES - 1;
        if (x1 > HRES - 1) x1 = HRES - 1;
        if (y0 > VRES - 1) y0 = VRES - 1;
        if (y1 > VRES - 1) y1 = VRES - 1;
        expErr = 0;
`else
        expErr = (x0 >= HRES || x1 >= HRES || y0 >= VRES || y1 >= VRES) ? 1 : 0;
`endif
        xmn = (x0 < x1) ? x0 : x1;
        xmx = (x0 < x1) ? x1 : x0;
        ymn = (y0 < y1) ? y0 : y1;
        ymx = (y0 < y1) ? y1 : y0;
        expQ.delete();
        if (expErr == 0) begin
          for (int y = ymn; y <= ymx; y++)
            for (int x = xmn; x <= xmx; x++)
              expQ.push_back(y * 256 + x);
        end
        npix = expQ.size();
        stalls = 0;
        expR = int'(i_cmd_red);
        expG = int'(i_cmd_green);
        expB = int'(i_cmd_blue);
        acceptCyc = cyc;
        lastAcceptCyc = cyc;
        lastDoneCyc = -1000;
        doneDue = (expErr != 0) ? cyc + 2 : -1;
        busy = 1;
      end
    end
    prevSrst = i_srst ? 1 : 0;
  end

  // Framebuffer backpressure: always ready, a 1,0,0 pattern, or random
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      case (readyMode)
        0: i_write_ready = 1'b1;
        1: begin
          i_write_ready = (patIdx % 3 == 0);
          patIdx++;
        end
        default: i_write_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic applyStimulus(input int x0, input int y0, input int x1, input int y1,
                               input int r, input int g, input int b);
    int n;
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b1;
    i_cmd_x0    = HW'(x0);
    i_cmd_x1    = HW'(x1);
    i_cmd_y0    = VW'(y0);
    i_cmd_y1    = VW'(y1);
    i_cmd_red   = CW'(r);
    i_cmd_green = CW'(g);
    i_cmd_blue  = CW'(b);
    n = 0;
    forever begin
      @(negedge i_clk);
      if (o_cmd_ready) break;
      n++;
      if (n > 20000) begin
        failNow("cmd_accept");
        break;
      end
    end
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b0;
    i_cmd_x0    = HW'($urandom);
    i_cmd_x1    = HW'($urandom);
    i_cmd_y0    = VW'($urandom);
    i_cmd_y1    = VW'($urandom);
    i_cmd_red   = CW'($urandom);
    i_cmd_green = CW'($urandom);
    i_cmd_blue  = CW'($urandom);
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (busy != 0 && n < 20000) begin
      @(posedge i_clk);
      n++;
    end
    if (busy != 0) failNow("wait_done");
    @(posedge i_clk);
  endtask

  task automatic runCmd(input int x0, input int y0, input int x1, input int y1,
                        input int r, input int g, input int b);
    writeLog.delete();
    applyStimulus(x0, y0, x1, y1, r, g, b);
    waitDone();
  endtask

  // Global watchdog so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized commands
  initial begin
    int n;
    int x0, x1, y0, y1;
    i_srst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_srst = 1'b0;
    @(posedge i_clk);

    // Basic 3x3 rectangle
    runCmd(2, 3, 4, 5, 15, 0, 0);
    checkOutput("s1_count", writeLog.size(), 9);
    checkOutput("s1_first", logAt(0), 3 * 256 + 2);
    checkOutput("s1_mid", logAt(4), 4 * 256 + 3);
    checkOutput("s1_last", logAt(8), 5 * 256 + 4);
    checkOutput("s1_latency", lastDoneCyc - lastAcceptCyc, 11);
    checkOutput("s1_error", lastErr, 0);

    // Swapped corners give the same raster sequence
    runCmd(4, 5, 2, 3, 15, 0, 0);
    checkOutput("s2_count", writeLog.size(), 9);
    checkOutput("s2_first", logAt(0), 3 * 256 + 2);
    checkOutput("s2_row2", logAt(3), 4 * 256 + 2);
    checkOutput("s2_last", logAt(8), 5 * 256 + 4);
    checkOutput("s2_latency", lastDoneCyc - lastAcceptCyc, 11);

    // Single pixel at the far corner of the frame
    runCmd(79, 59, 79, 59, 1, 2, 3);
    checkOutput("s3_count", writeLog.size(), 1);
    checkOutput("s3_pixel", logAt(0), 59 * 256 + 79);
    checkOutput("s3_latency", lastDoneCyc - lastAcceptCyc, 3);

    // Backpressure pattern on a 2x2 box
    readyMode = 1;
    patIdx = 0;
    runCmd(0, 0, 1, 1, 5, 10, 7);
    readyMode = 0;
    checkOutput("s4_count", writeLog.size(), 4);
    checkOutput("s4_p0", logAt(0), 0);
    checkOutput("s4_p1", logAt(1), 1);
    checkOutput("s4_p2", logAt(2), 256);
    checkOutput("s4_p3", logAt(3), 257);

    // Out-of-range corner
    runCmd(70, 10, 90, 11, 3, 3, 3);
`ifdef RASTER_CLIP_EN
    checkOutput("s5_count", writeLog.size(), 20);
    checkOutput("s5_first", logAt(0), 10 * 256 + 70);
    checkOutput("s5_last", logAt(19), 11 * 256 + 79);
    checkOutput("s5_error", lastErr, 0);
    checkOutput("s5_latency", lastDoneCyc - lastAcceptCyc, 22);
`else
    checkOutput("s5_count", writeLog.size(), 0);
    checkOutput("s5_error", lastErr, 1);
    checkOutput("s5_latency", lastDoneCyc - lastAcceptCyc, 2);
`endif

    // Reset in the middle of drawing abandons the command
    writeLog.delete();
    applyStimulus(2, 3, 4, 5, 15, 0, 0);
    n = 0;
    while (writeLog.size() < 3 && n < 100) begin
      @(posedge i_clk);
      n++;
    end
    if (writeLog.size() < 3) failNow("s6_third_write");
    #1;
    i_srst = 1'b1;
    @(posedge i_clk);
    #1;
    i_srst = 1'b0;
    n = lastDoneCyc;
    repeat (15) @(posedge i_clk);
    checkOutput("s6_no_done", lastDoneCyc, n);
    checkOutput("s6_writes", writeLog.size(), 3);
    checkOutput("s6_ready", int'(o_cmd_ready), 1);
    runCmd(2, 3, 4, 5, 9, 8, 7);
    checkOutput("s6_new_count", writeLog.size(), 9);
    checkOutput("s6_new_last", logAt(8), 5 * 256 + 4);

    // Randomized back-to-back commands with random backpressure
    readyMode = 2;
    for (int i = 0; i < 30; i++) begin
      x0 = $urandom_range(0, 85);
      x1 = x0 + $urandom_range(0, 20) - 10;
      if (x1 < 0) x1 = 0;
      if (x1 > 127) x1 = 127;
      y0 = $urandom_range(0, 62);
      y1 = y0 + $urandom_range(0, 12) - 6;
      if (y1 < 0) y1 = 0;
      if (y1 > 63) y1 = 63;
      applyStimulus(x0, y0, x1, y1, $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 15));
    end
    waitDone();
    readyMode = 0;
    repeat (4) @(posedge i_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
